// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative RV32M multiply/divide sequencer.
// One 33-bit add/subtract datapath is stepped one bit per cycle for 32
// iterations. The result is then sign-corrected and returned with a
// one-cycle done pulse.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start, flush        - launch request (IDLE/DONE only), synchronous abort
//   op                  - RISC-V funct3 (MUL..REMU)
//   operand_a/operand_b - rs1/rs2, captured on an accepted start
//   busy                - high while CALC or FIX
//   done                - single-cycle pulse; result valid while high
//   result              - final value, held until the next accepted start
module alu_muldiv_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CNT_W = 6;
    localparam int unsigned SUM_W = XLEN + 1;
    localparam int unsigned PRD_W = 2 * XLEN;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(31);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    hi_q, hi_d;      // product high half / partial remainder
    logic [XLEN-1:0]    lo_q, lo_d;      // multiplier / dividend -> quotient
    logic [XLEN-1:0]    opnd_q, opnd_d;  // multiplicand or divisor magnitude
    logic [2:0]         op_q, op_d;
    logic               neg_q, neg_d;    // negate the selected result in FIX
    logic [XLEN-1:0]    result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Start-time operand decode: signedness, magnitudes, special cases
    logic            a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            neg_in, div_zero, div_ovf;
    logic [XLEN-1:0] special_res;

    always_comb begin
        a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        sign_a   = a_signed & operand_a[XLEN-1];
        sign_b   = b_signed & operand_b[XLEN-1];
        mag_a    = sign_a ? (~operand_a + XLEN'(1)) : operand_a;
        mag_b    = sign_b ? (~operand_b + XLEN'(1)) : operand_b;
        // Remainder takes the dividend's sign; product and quotient the XOR
        neg_in   = (op == OP_REM) ? sign_a : (sign_a ^ sign_b);
        div_zero = op[2] && (operand_b == '0);
        div_ovf  = ((op == OP_DIV) || (op == OP_REM))
                   && (operand_a == {1'b1, {(XLEN-1){1'b0}}})
                   && (operand_b == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = op[1] ? operand_a : '1;
        end else if (div_ovf) begin
            special_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // Shared adder: add for multiply, subtract divisor for divide
    logic             is_div;
    logic [SUM_W-1:0] add_lhs, add_rhs, add_sum;

    always_comb begin
        is_div  = op_q[2];
        add_lhs = is_div ? {hi_q, lo_q[XLEN-1]} : {1'b0, hi_q};
        add_rhs = {1'b0, opnd_q};
        add_sum = add_lhs + (is_div ? ~add_rhs : add_rhs) + SUM_W'(is_div);
    end

    // Sign correction and result selection used in FIX
    logic [PRD_W-1:0] prod, prod_fix;
    logic [XLEN-1:0]  div_val, div_fix, fix_res;

    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = neg_q ? (~prod + PRD_W'(1)) : prod;
        div_val  = op_q[1] ? hi_q : lo_q;
        div_fix  = neg_q ? (~div_val + XLEN'(1)) : div_val;
        if (is_div) begin
            fix_res = div_fix;
        end else if (op_q == OP_MUL) begin
            fix_res = prod_fix[XLEN-1:0];
        end else begin
            fix_res = prod_fix[PRD_W-1:XLEN];
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = result_q;

        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_d  = op;
                        neg_d = neg_in;
                        cnt_d = '0;
                        if (div_zero || div_ovf) begin
                            result_d = special_res;
                            state_d  = S_DONE;
                        end else begin
                            hi_d    = '0;
                            lo_d    = op[2] ? mag_a : mag_b;
                            opnd_d  = op[2] ? mag_b : mag_a;
                            state_d = S_CALC;
                        end
                    end else if (state_q == S_DONE) begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC: begin
                    if (is_div) begin
                        // Restoring step: keep the difference only when no borrow
                        if (!add_sum[XLEN]) begin
                            hi_d = add_sum[XLEN-1:0];
                            lo_d = {lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            hi_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
                            lo_d = {lo_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        // Shift-add: the carry out of the adder enters the top bit
                        if (lo_q[0]) begin
                            {hi_d, lo_d} = {add_sum, lo_q[XLEN-1:1]};
                        end else begin
                            {hi_d, lo_d} = {1'b0, hi_q, lo_q[XLEN-1:1]};
                        end
                    end
                    if (cnt_q == LAST_ITER) begin
                        cnt_d   = '0;
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_FIX: begin
                    result_d = fix_res;
                    state_d  = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed RV32M cases, special
// cases, control/abort scenarios and a few randomized operations checked
// against an arithmetic reference model through an expected-result queue.
module tb_alu_muldiv_seq;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          errors   = 0;
    int          done_cnt = 0;
    int          cyc      = 0;
    logic [31:0] last_res = '0;

    alu_muldiv_seq #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .flush     (flush),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pop and compare on every done pulse
    always @(negedge clk) begin : mon
        exp_t e;
        if (done === 1'b1) begin
            done_cnt++;
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL spurious_done: observed done at cycle %0d expected none", cyc);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("result", 64'(result), 64'(e.res));
                chk("busy_at_done", 64'(busy), 64'(0));
                last_res = e.res;
            end
        end
    end

    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic               ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            MUL:    begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
            MULH:   begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
            MULHSU: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return sp[63:32]; end
            MULHU:  begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            DIVU:   begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            REM:    begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && (b == 0)) return 0;
        if ((o == DIV || o == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 33;
    endfunction

    // Drive one start cycle from the current negedge; optionally expect a result
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int lat, input bit push);
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        if (push) sb.push_back('{exp_res, cyc + 1 + lat});
        @(negedge clk);
        start     = 1'b0;
        op        = 3'($urandom);
        operand_a = $urandom;
        operand_b = $urandom;
    endtask

    task automatic wait_done(input int snap, input int budget);
        int i = 0;
        #1;
        while (done_cnt <= snap && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        checks++;
        assert (done_cnt > snap) else begin
            errors++;
            $error("FAIL done_timeout: observed %0d done pulses expected more than %0d", done_cnt, snap);
        end
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res);
        int lat;
        int snap;
        lat  = ref_lat(o, a, b);
        snap = done_cnt;
        @(negedge clk);
        issue(o, a, b, exp_res, lat, 1'b1);
        #1;
        chk("busy_after_start", 64'(busy), 64'(lat != 0));
        wait_done(snap, 40);
    endtask

    initial begin : main
        int n;
        int snap;
        logic [31:0] prev;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_result", 64'(result), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic
        run(MUL,    32'd7,          32'd6,          32'h0000_002A);
        run(MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE);
        run(MULH,   32'hFFFF_FFFF,  32'h0000_0002,  32'hFFFF_FFFF);
        run(MULHSU, 32'hFFFF_FFFF,  32'h0000_0002,  32'hFFFF_FFFF);
        run(MULHU,  32'hFFFF_FFFF,  32'h0000_0002,  32'h0000_0001);
        run(DIV,    32'hFFFF_FFF9,  32'h0000_0002,  32'hFFFF_FFFD);
        run(REM,    32'hFFFF_FFF9,  32'h0000_0002,  32'hFFFF_FFFF);
        run(DIVU,   32'hFFFF_FFF9,  32'h0000_0002,  32'h7FFF_FFFC);
        run(REMU,   32'd1000,       32'd7,          32'd6);

        // Special cases: done one cycle after the start edge, busy stays low
        run(DIVU,   32'h0000_1234,  32'h0,          32'hFFFF_FFFF);
        run(REM,    32'h0000_1234,  32'h0,          32'h0000_1234);
        run(DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000);
        run(REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000);

        // Randomized operations against the reference model
        for (int k = 0; k < 8; k++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            if (k == 5) rb = 32'($urandom_range(1, 9));
            run(ro, ra, rb, ref_res(ro, ra, rb));
        end

        // Start during CALC is ignored
        snap = done_cnt;
        @(negedge clk);
        issue(MUL, 32'd100, 32'd200, 32'd20000, 33, 1'b1);
        n = cyc;
        while (cyc < n + 9) @(negedge clk);
        issue(MULHU, 32'd5, 32'd5, 32'h0, 0, 1'b0);
        wait_done(snap, 40);
        repeat (40) @(negedge clk);
        #1;
        chk("single_done", 64'(done_cnt - snap), 64'(1));

        // Back-to-back launch in the DONE cycle
        snap = done_cnt;
        @(negedge clk);
        issue(DIVU, 32'd1000, 32'd7, 32'd142, 33, 1'b1);
        n = cyc;
        while (cyc < n + 33) @(negedge clk);
        issue(REMU, 32'd1000, 32'd7, 32'd6, 33, 1'b1);
        wait_done(snap + 1, 80);
        chk("b2b_dones", 64'(done_cnt - snap), 64'(2));

        // Flush mid-calculation
        repeat (2) @(negedge clk);
        prev = last_res;
        snap = done_cnt;
        issue(MUL, 32'd3, 32'd3, 32'h0, 0, 1'b0);
        n = cyc;
        while (cyc < n + 4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("busy_after_flush", 64'(busy), 64'(0));
        repeat (40) @(negedge clk);
        #1;
        chk("no_done_after_flush", 64'(done_cnt), 64'(snap));
        chk("result_held_flush", 64'(result), 64'(prev));

        // Asynchronous reset mid-calculation
        snap = done_cnt;
        @(negedge clk);
        issue(MULH, 32'hFFFF_FFFF, 32'h2, 32'h0, 0, 1'b0);
        n = cyc;
        while (cyc < n + 11) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy), 64'(0));
        chk("async_rst_done", 64'(done), 64'(0));
        chk("async_rst_result", 64'(result), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        chk("no_done_after_rst", 64'(done_cnt), 64'(snap));
        chk("busy_after_rst", 64'(busy), 64'(0));

        // Recovery after reset
        run(MUL, 32'd7, 32'd6, 32'h0000_002A);
        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
